// File: rtl/fetch_ctrl_pkg.sv
// Shared core definitions for the fetch controller: widths, PC step and FSM state encoding.
package fetch_ctrl_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 64'd4;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DROP  = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  function automatic logic isAligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response and decode hand-off signals of the fetch controller.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic            o_IMemReq;
  logic [XLEN-1:0] o_IMemAddr;
  logic            i_IMemGnt;
  logic            i_IMemRValid;
  logic [ILEN-1:0] i_IMemRData;
  logic            o_InstrValid;
  logic [ILEN-1:0] o_Instr;
  logic [XLEN-1:0] o_InstrPC;
  logic            i_DecodeReady;

  modport master (
    output o_IMemReq, o_IMemAddr, o_InstrValid, o_Instr, o_InstrPC,
    input  i_IMemGnt, i_IMemRValid, i_IMemRData, i_DecodeReady
  );

  modport slave (
    input  o_IMemReq, o_IMemAddr, o_InstrValid, o_Instr, o_InstrPC,
    output i_IMemGnt, i_IMemRValid, i_IMemRData, i_DecodeReady
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller with branch redirect, response squashing
// and a sticky misaligned-target halt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 64'h0000_0000_0000_0000
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Branch,
  input  logic            i_Zero,
  input  logic [XLEN-1:0] i_BranchPC,
  input  logic [XLEN-1:0] i_Immediate,
  output logic            o_Misaligned,
  fetch_ctrl_if.master    bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instrPc_q, instrPc_d;
  logic            misaligned_q, misaligned_d;
  logic            reqEn_q;

  logic            taken;
  logic [XLEN-1:0] target;
  logic            grant;
  logic            halted;

  // reqEn_q keeps the request low while in reset and until the first edge after release.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_VECTOR;
      instr_q      <= '0;
      instrPc_q    <= '0;
      misaligned_q <= 1'b0;
      reqEn_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instrPc_q    <= instrPc_d;
      misaligned_q <= misaligned_d;
      reqEn_q      <= 1'b1;
    end
  end

  assign taken  = i_Branch & i_Zero;
  assign target = i_BranchPC + i_Immediate;
  assign grant  = reqEn_q & bus.i_IMemGnt;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instrPc_d    = instrPc_q;
    misaligned_d = misaligned_q;

    // A misaligned taken target overrides every other transition and leaves the PC alone.
    if (state_q != ST_HALT && taken && !isAligned(target)) begin
      state_d      = ST_HALT;
      misaligned_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (taken) begin
            pc_d    = target;
            state_d = grant ? ST_DROP : ST_FETCH;
          end else if (grant) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (taken) begin
            pc_d    = target;
            state_d = bus.i_IMemRValid ? ST_FETCH : ST_DROP;
          end else if (bus.i_IMemRValid) begin
            instr_d   = bus.i_IMemRData;
            instrPc_d = pc_q;
            state_d   = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (taken) begin
            pc_d    = target;
            state_d = ST_FETCH;
          end else if (bus.i_DecodeReady) begin
            pc_d    = pc_q + PC_INC;
            state_d = ST_FETCH;
          end
        end
        ST_DROP: begin
          if (taken) begin
            pc_d = target;
          end
          if (bus.i_IMemRValid) begin
            state_d = ST_FETCH;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  assign halted           = (state_q == ST_HALT);
  assign bus.o_IMemReq    = (state_q == ST_FETCH) && reqEn_q;
  assign bus.o_IMemAddr   = halted ? '0 : pc_q;
  assign bus.o_InstrValid = (state_q == ST_HOLD);
  assign bus.o_Instr      = halted ? '0 : instr_q;
  assign bus.o_InstrPC    = halted ? '0 : instrPc_q;
  assign o_Misaligned     = misaligned_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised and directed bench for fetch_ctrl, checked against a transaction-level model.
module tb_fetch_ctrl;

  localparam logic [63:0] RV = 64'hFFFF_FFFF_FFFF_FFF4;

  logic        clk;
  logic        rstN;
  logic        br;
  logic        zero;
  logic [63:0] bpc;
  logic [63:0] imm;
  logic        mis;

  int checks = 0;
  int errors = 0;

  // Model: what the fetcher owes the world, not how it is encoded.
  logic [63:0] mPc;
  bit          mOut;
  bit          mDiscard;
  bit          mHave;
  logic [31:0] mInstr;
  logic [63:0] mInstrPc;
  bit          mHalt;
  bit          mMis;
  bit          mStarted;
  bit          envPending;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_VECTOR(RV)) dut (
    .i_Clock     (clk),
    .i_Reset     (rstN),
    .i_Branch    (br),
    .i_Zero      (zero),
    .i_BranchPC  (bpc),
    .i_Immediate (imm),
    .o_Misaligned(mis),
    .bus         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit modelReq();
    return mStarted && !mHalt && !mOut && !mHave;
  endfunction

  task automatic modelReset();
    mPc        = RV;
    mOut       = 0;
    mDiscard   = 0;
    mHave      = 0;
    mInstr     = '0;
    mInstrPc   = '0;
    mHalt      = 0;
    mMis       = 0;
    mStarted   = 0;
    envPending = 0;
  endtask

  task automatic checkOutputs();
    checkOutput("req", {63'd0, bus.o_IMemReq}, {63'd0, modelReq()});
    if (modelReq()) checkOutput("addr", bus.o_IMemAddr, mPc);
    checkOutput("valid", {63'd0, bus.o_InstrValid}, {63'd0, mHave && !mHalt});
    if (mHave && !mHalt) begin
      checkOutput("instr", {32'd0, bus.o_Instr}, {32'd0, mInstr});
      checkOutput("instrPc", bus.o_InstrPC, mInstrPc);
    end
    if (mHalt) begin
      checkOutput("haltInstr", {32'd0, bus.o_Instr}, 64'd0);
      checkOutput("haltInstrPc", bus.o_InstrPC, 64'd0);
      checkOutput("haltAddr", bus.o_IMemAddr, 64'd0);
    end
    checkOutput("misaligned", {63'd0, mis}, {63'd0, mMis});
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge, then check.
  task automatic applyStimulus(input bit g, input bit rv, input bit rdy, input bit b,
                               input bit z, input logic [63:0] p, input logic [63:0] im);
    logic [63:0] tgt;
    logic [31:0] rdata;
    bit          gntAcc;
    bit          rvAct;
    bit          tk;
    rdata = $urandom;
    rvAct = rv && envPending;
    bus.i_IMemGnt     = g;
    bus.i_IMemRValid  = rvAct;
    bus.i_IMemRData   = rdata;
    bus.i_DecodeReady = rdy;
    br   = b;
    zero = z;
    bpc  = p;
    imm  = im;
    gntAcc = g && modelReq();
    if (rvAct) envPending = 0;
    if (gntAcc) envPending = 1;
    tk  = b && z;
    tgt = p + im;
    if (!mHalt) begin
      if (tk && tgt[1:0] != 2'b00) begin
        mHalt = 1;
        mMis  = 1;
      end else if (mHave) begin
        if (tk) begin
          mHave = 0;
          mPc   = tgt;
        end else if (rdy) begin
          mHave = 0;
          mPc   = mPc + 64'd4;
        end
      end else if (mOut) begin
        if (rvAct) begin
          mOut = 0;
          if (!mDiscard && !tk) begin
            mHave    = 1;
            mInstr   = rdata;
            mInstrPc = mPc;
          end
          mDiscard = 0;
        end else if (tk) begin
          mDiscard = 1;
        end
        if (tk) mPc = tgt;
      end else begin
        if (gntAcc) begin
          mOut     = 1;
          mDiscard = tk;
        end
        if (tk) mPc = tgt;
      end
    end
    mStarted = 1;
    @(negedge clk);
    checkOutputs();
  endtask

  task automatic resetDut();
    rstN = 1'b0;
    #1;
    modelReset();
    checkOutputs();
    checkOutput("rstInstr", {32'd0, bus.o_Instr}, 64'd0);
    checkOutput("rstInstrPc", bus.o_InstrPC, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rstReqHeld", {63'd0, bus.o_IMemReq}, 64'd0);
    @(negedge clk);
    #1;
    rstN = 1'b1;
  endtask

  task automatic randomCycle();
    logic [63:0] p;
    logic [63:0] im;
    p  = {$urandom, $urandom};
    im = {$urandom, $urandom};
    p[1:0] = 2'b00;
    if ($urandom_range(0, 19) != 0) im[1:0] = 2'b00;
    applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 1), p, im);
  endtask

  initial begin
    rstN = 1'b0;
    br = 0; zero = 0; bpc = '0; imm = '0;
    bus.i_IMemGnt = 0; bus.i_IMemRValid = 0; bus.i_IMemRData = '0; bus.i_DecodeReady = 0;
    #2;
    resetDut();

    // Zero-wait stream across the 64-bit wrap: FFF4, FFF8, FFFC, 0, then request at 4.
    repeat (13) applyStimulus(1, 1, 1, 0, 0, 64'd0, 64'd0);
    checkOutput("wrapAddr", bus.o_IMemAddr, 64'h4);

    // Grant withheld, then decode stalls with the instruction held.
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 64'd0, 64'd0);
    applyStimulus(1, 0, 0, 0, 0, 64'd0, 64'd0);
    applyStimulus(0, 1, 0, 0, 0, 64'd0, 64'd0);
    repeat (5) applyStimulus(0, 0, 0, 1, 0, 64'h40, 64'd4);
    checkOutput("stallPc", bus.o_InstrPC, 64'h4);
    applyStimulus(0, 0, 1, 0, 0, 64'd0, 64'd0);

    // Redirect in WAIT coinciding with the response.
    applyStimulus(1, 0, 0, 0, 0, 64'd0, 64'd0);
    applyStimulus(0, 1, 0, 1, 1, 64'h100, 64'hFFFF_FFFF_FFFF_FFF0);
    checkOutput("waitRedirAddr", bus.o_IMemAddr, 64'hF0);

    // Redirect coinciding with grant: first response must be dropped.
    applyStimulus(1, 0, 0, 1, 1, 64'h200, 64'h40);
    applyStimulus(0, 1, 0, 0, 0, 64'd0, 64'd0);
    checkOutput("dropValid", {63'd0, bus.o_InstrValid}, 64'd0);
    checkOutput("dropAddr", bus.o_IMemAddr, 64'h240);

    for (int i = 0; i < 3000; i++) begin
      if ((mHalt && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) resetDut();
      else randomCycle();
    end

    // Misaligned target halts until reset.
    resetDut();
    applyStimulus(0, 0, 0, 1, 1, 64'h100, 64'h2);
    repeat (4) applyStimulus(1, 1, 1, 0, 0, 64'd0, 64'd0);
    checkOutput("haltReq", {63'd0, bus.o_IMemReq}, 64'd0);
    checkOutput("haltMis", {63'd0, mis}, 64'd1);

    // Asynchronous reset in the middle of WAIT.
    resetDut();
    applyStimulus(0, 0, 0, 0, 0, 64'd0, 64'd0);
    applyStimulus(1, 0, 0, 0, 0, 64'd0, 64'd0);
    resetDut();
    applyStimulus(1, 1, 1, 0, 0, 64'd0, 64'd0);
    checkOutput("postRstAddr", bus.o_IMemAddr, RV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
